// File: rtl/xadac_vrf_sb.sv
// Vector register scoreboard and issue gate: tracks outstanding VRF writes, stalls
// RAW/WAW/capacity hazards and implements a fence that drains all pending writes.
module xadac_vrf_sb #(
    parameter int NoVregs = 32,
    parameter int NoVs    = 3,
    parameter int MaxOut  = 4,
    parameter int AW      = $clog2(NoVregs),
    parameter int CW      = $clog2(MaxOut + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NoVs*AW-1:0]   in_vs_addr,
    input  logic [NoVs-1:0]      in_vs_used,
    input  logic [AW-1:0]        in_vd_addr,
    input  logic                 in_vd_write,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 rsp_valid,
    input  logic                 rsp_ready,
    input  logic [AW-1:0]        rsp_vd_addr,
    input  logic                 rsp_vd_write,
    input  logic                 fence_req,
    output logic                 fence_ack,
    output logic [NoVregs-1:0]   busy_o,
    output logic [CW-1:0]        out_cnt_o
);

    // Handshake: a transfer happens when out_valid && out_ready; in_ready is
    // out_ready gated by the hazard stall and never looks at in_valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NoVregs-1:0] busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic raw, waw, full, stall;
    logic issue, complete;

    // Hazards use registered busy/cnt only, so a completion never bypasses into the same cycle.
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < NoVs; i++) begin
            if (in_vs_used[i] && busy_q[in_vs_addr[i*AW +: AW]]) begin
                raw = 1'b1;
            end
        end
    end

    assign waw   = in_vd_write && busy_q[in_vd_addr];
    assign full  = in_vd_write && (cnt_q == CW'(MaxOut));
    assign stall = raw || waw || full || (state_q != IDLE);

    assign out_valid = in_valid && !stall;
    assign in_ready  = out_ready && !stall;

    assign issue = out_valid && out_ready && in_vd_write;
    // A completion for a register that is not busy (e.g. issued before a reset) is dropped.
    assign complete = rsp_valid && rsp_ready && rsp_vd_write && busy_q[rsp_vd_addr];

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (complete) begin
            busy_d[rsp_vd_addr] = 1'b0;
        end
        if (issue) begin
            busy_d[in_vd_addr] = 1'b1;
        end
        if (issue && !complete) begin
            cnt_d = cnt_q + CW'(1);
        end else if (complete && !issue) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fence_req) state_d = DRAIN;
            DRAIN:   if (cnt_q == '0) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            busy_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fence_ack = (state_q == ACK);
    assign busy_o    = busy_q;
    assign out_cnt_o = cnt_q;

endmodule

// File: tb/tb_xadac_vrf_sb.sv
// Directed bench for xadac_vrf_sb: hazards, capacity, fence timing and async reset.
module tb_xadac_vrf_sb;
    localparam int NoVregs = 32;
    localparam int NoVs    = 3;
    localparam int MaxOut  = 4;
    localparam int AW      = 5;
    localparam int CW      = 3;

    logic               clk = 1'b0;
    logic               rstn;
    logic               in_valid;
    logic               in_ready;
    logic [NoVs*AW-1:0] in_vs_addr;
    logic [NoVs-1:0]    in_vs_used;
    logic [AW-1:0]      in_vd_addr;
    logic               in_vd_write;
    logic               out_valid;
    logic               out_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [AW-1:0]      rsp_vd_addr;
    logic               rsp_vd_write;
    logic               fence_req;
    logic               fence_ack;
    logic [NoVregs-1:0] busy_o;
    logic [CW-1:0]      out_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    xadac_vrf_sb #(.NoVregs(NoVregs), .NoVs(NoVs), .MaxOut(MaxOut)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vs_addr(in_vs_addr), .in_vs_used(in_vs_used),
        .in_vd_addr(in_vd_addr), .in_vd_write(in_vd_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_vd_addr(rsp_vd_addr), .rsp_vd_write(rsp_vd_write),
        .fence_req(fence_req), .fence_ack(fence_ack),
        .busy_o(busy_o), .out_cnt_o(out_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outstanding count must always equal the number of busy registers.
    always @(negedge clk) begin
        if (rstn === 1'b1) check("inv_cnt_popcount", 32'(out_cnt_o), 32'($countones(busy_o)));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [NoVs-1:0] used, input logic [AW-1:0] a0,
                       input logic [AW-1:0] vd, input logic wr);
        in_valid    = v;
        in_vs_used  = used;
        in_vs_addr  = {AW'(0), AW'(0), a0};
        in_vd_addr  = vd;
        in_vd_write = wr;
    endtask

    task automatic rsp(input logic v, input logic [AW-1:0] vd);
        rsp_valid    = v;
        rsp_ready    = v;
        rsp_vd_addr  = vd;
        rsp_vd_write = v;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        out_ready = 1'b0;
        fence_req = 1'b0;
        req(0, 3'b000, 5'd0, 5'd0, 0);
        rsp(0, 5'd0);
        repeat (2) cyc();
        check("rst_busy", busy_o, 32'h0);
        check("rst_cnt", 32'(out_cnt_o), 0);
        check("rst_ack", 32'(fence_ack), 0);
        check("rst_in_ready_no_out_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        rstn = 1'b1;
        cyc();

        // First issue: read v5, write v7
        req(1, 3'b001, 5'd5, 5'd7, 1);
        #1 check("first_out_valid", 32'(out_valid), 1);
        cyc();
        req(0, 3'b000, 5'd0, 5'd0, 0);
        check("first_busy", busy_o, 32'h0000_0080);
        check("first_cnt", 32'(out_cnt_o), 1);

        // RAW on v7; completion in the same cycle must not bypass
        req(1, 3'b001, 5'd7, 5'd0, 0);
        #1 check("raw_out_valid", 32'(out_valid), 0);
        check("raw_in_ready", 32'(in_ready), 0);
        rsp(1, 5'd7);
        #1 check("raw_no_bypass", 32'(out_valid), 0);
        cyc();
        rsp(0, 5'd0);
        check("raw_busy_cleared", busy_o, 32'h0);
        check("raw_forward_next", 32'(out_valid), 1);
        check("raw_in_ready_next", 32'(in_ready), 1);
        cyc();
        req(0, 3'b000, 5'd0, 5'd0, 0);

        // WAW on v3; an unused source naming v3 is ignored
        req(1, 3'b000, 5'd0, 5'd3, 1);
        cyc();
        req(1, 3'b000, 5'd0, 5'd3, 1);
        #1 check("waw_out_valid", 32'(out_valid), 0);
        check("waw_in_ready", 32'(in_ready), 0);
        req(1, 3'b000, 5'd3, 5'd4, 1);
        #1 check("unused_src_forward", 32'(out_valid), 1);
        cyc();
        req(0, 3'b000, 5'd0, 5'd0, 0);
        check("waw_busy", busy_o, 32'h0000_0018);
        check("waw_cnt", 32'(out_cnt_o), 2);
        rsp(1, 5'd3); cyc();
        rsp(1, 5'd4); cyc();
        rsp(0, 5'd0);
        check("waw_drained", 32'(out_cnt_o), 0);

        // Capacity: v1..v4 back to back
        for (int i = 1; i <= 4; i++) begin
            req(1, 3'b000, 5'd0, AW'(i), 1);
            #1 check("cap_issue", 32'(out_valid), 1);
            cyc();
        end
        req(0, 3'b000, 5'd0, 5'd0, 0);
        check("cap_cnt", 32'(out_cnt_o), 4);
        check("cap_busy", busy_o, 32'h0000_001E);
        req(1, 3'b000, 5'd0, 5'd9, 1);
        #1 check("full_out_valid", 32'(out_valid), 0);
        check("full_in_ready", 32'(in_ready), 0);
        req(1, 3'b000, 5'd0, 5'd9, 0);
        #1 check("full_nowrite_forward", 32'(out_valid), 1);
        req(1, 3'b000, 5'd0, 5'd9, 1);
        rsp(1, 5'd2);
        #1 check("full_no_bypass", 32'(out_valid), 0);
        cyc();
        rsp(0, 5'd0);
        check("full_after_complete", 32'(out_valid), 1);
        cyc();
        req(0, 3'b000, 5'd0, 5'd0, 0);
        check("cap_busy2", busy_o, 32'h0000_021A);
        check("cap_cnt2", 32'(out_cnt_o), 4);

        // Fence with two writes outstanding (v4, v9)
        rsp(1, 5'd1); cyc();
        rsp(1, 5'd3); cyc();
        rsp(0, 5'd0);
        check("fence_pre_cnt", 32'(out_cnt_o), 2);
        fence_req = 1'b1;
        req(1, 3'b000, 5'd0, 5'd0, 0);
        #1 check("fence_same_cycle_issue", 32'(out_valid), 1);
        cyc();
        fence_req = 1'b0;
        check("drain_block", 32'(out_valid), 0);
        check("drain_in_ready", 32'(in_ready), 0);
        check("drain_ack", 32'(fence_ack), 0);
        rsp(1, 5'd4); cyc();
        check("drain_block2", 32'(out_valid), 0);
        rsp(1, 5'd9); cyc();
        rsp(0, 5'd0);
        check("drain_cnt0", 32'(out_cnt_o), 0);
        check("drain_ack_n1", 32'(fence_ack), 0);
        check("drain_block_n1", 32'(out_valid), 0);
        cyc();
        check("ack_pulse", 32'(fence_ack), 1);
        check("ack_block", 32'(out_valid), 0);
        cyc();
        check("ack_done", 32'(fence_ack), 0);
        check("resume_issue", 32'(out_valid), 1);
        req(0, 3'b000, 5'd0, 5'd0, 0);

        // Fence with nothing outstanding
        fence_req = 1'b1;
        cyc();
        fence_req = 1'b0;
        check("fence0_n1", 32'(fence_ack), 0);
        cyc();
        check("fence0_n2", 32'(fence_ack), 1);
        cyc();
        check("fence0_n3", 32'(fence_ack), 0);

        // Asynchronous reset mid-operation
        for (int i = 1; i <= 3; i++) begin
            req(1, 3'b000, 5'd0, AW'(i), 1);
            cyc();
        end
        req(0, 3'b000, 5'd0, 5'd0, 0);
        check("mid_cnt", 32'(out_cnt_o), 3);
        #1 rstn = 1'b0;
        #1 check("async_busy", busy_o, 32'h0);
        check("async_cnt", 32'(out_cnt_o), 0);
        cyc();
        #2 rstn = 1'b1;
        cyc();
        rsp(1, 5'd1);
        cyc();
        rsp(0, 5'd0);
        check("stale_rsp_cnt", 32'(out_cnt_o), 0);
        check("stale_rsp_busy", busy_o, 32'h0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
